// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory arbiter: access sizes, grant source ids and
// the FSM state type. The ERR state exists only when MEM_ARB_ALIGN_CHK_EN is
// defined.
package mem_arb_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_D  = 1'b1;

`ifdef MEM_ARB_ALIGN_CHK_EN
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, ERR} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;
`endif

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatting for the data port. The store side produces
// byte enables, replicated write data and the misalignment flag from the raw
// request. The load side picks the addressed lane out of the memory word and
// sign- or zero-extends it.
module mem_lane_fmt
  import mem_arb_pkg::*;
(
  input  logic [1:0]  i_st_lsb,
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_st_wdata,
  input  logic [1:0]  i_ld_lsb,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_signed,
  input  logic [31:0] i_ld_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic        o_misalign,
  output logic [31:0] o_ld_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  // Byte enables, lane replication and alignment check (size 11 acts as word)
  always_comb begin
    o_be       = 4'b1111;
    o_wdata    = i_st_wdata;
    o_misalign = (i_st_lsb != 2'b00);
    case (i_st_size)
      SZ_HALF: begin
        o_be       = 4'b0011 << {i_st_lsb[1], 1'b0};
        o_wdata    = {2{i_st_wdata[15:0]}};
        o_misalign = i_st_lsb[0];
      end
      SZ_BYTE: begin
        o_be       = 4'b0001 << i_st_lsb;
        o_wdata    = {4{i_st_wdata[7:0]}};
        o_misalign = 1'b0;
      end
      default: ;
    endcase
  end

  // Addressed lane selection; a half access only looks at address bit 1
  always_comb begin
    w_half = i_ld_lsb[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    case (i_ld_lsb)
      2'd1:    w_byte = i_ld_rdata[15:8];
      2'd2:    w_byte = i_ld_rdata[23:16];
      2'd3:    w_byte = i_ld_rdata[31:24];
      default: w_byte = i_ld_rdata[7:0];
    endcase
  end

  // Sign or zero extension of the selected lane
  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_size)
      SZ_HALF: o_ld_data = {{16{i_ld_signed & w_half[15]}}, w_half};
      SZ_BYTE: o_ld_data = {{24{i_ld_signed & w_byte[7]}}, w_byte};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Registered-grant arbiter sharing one memory port between instruction fetch
// and the data port. Data has fixed priority over fetch. No new grant is made
// in a cycle where an ack is pulsing, so the acked requester has a cycle to
// drop its request and a waiting requester is granted in the next IDLE cycle.
// Define MEM_ARB_ALIGN_CHK_EN to turn misaligned data requests into an
// immediate error ack instead of a truncated-address access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [31:0]       if_rdata_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [1:0]        d_size_i,
  input  logic              d_signed_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  output logic [31:0]       d_rdata_o,
  output logic              d_ack_o,
  output logic              d_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  input  logic              mem_ready_i
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_grant_d;
  logic              w_grant_if;
  logic              w_busy;
  logic              w_ack_now;

  logic [ADDR_W-3:0] r_addr_hi;
  logic [1:0]        r_lsb;
  logic [1:0]        r_size;
  logic              r_we;
  logic              r_signed;
  logic              r_src;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_if_rdata;
  logic [31:0]       r_d_rdata;
  logic              r_if_ack;
  logic              r_d_ack;

  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_ld_data;
  logic              w_misalign;
  logic [1:0]        w_unused_if_lsb;

  mem_lane_fmt u_fmt (
    .i_st_lsb    (d_addr_i[1:0]),
    .i_st_size   (d_size_i),
    .i_st_wdata  (d_wdata_i),
    .i_ld_lsb    (r_lsb),
    .i_ld_size   (r_size),
    .i_ld_signed (r_signed),
    .i_ld_rdata  (mem_rdata_i),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_misalign  (w_misalign),
    .o_ld_data   (w_ld_data)
  );

  assign w_busy          = (r_state == BUSY_IF) || (r_state == BUSY_D);
  assign w_ack_now       = r_if_ack | r_d_ack;
  assign w_unused_if_lsb = if_addr_i[1:0];

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Fixed-priority arbitration and next-state selection
  always_comb begin
    w_state_nxt = r_state;
    w_grant_d   = 1'b0;
    w_grant_if  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_ack_now) begin
          if (d_req_i) begin
            w_grant_d = 1'b1;
`ifdef MEM_ARB_ALIGN_CHK_EN
            w_state_nxt = w_misalign ? ERR : BUSY_D;
`else
            w_state_nxt = BUSY_D;
`endif
          end else if (if_req_i) begin
            w_grant_if  = 1'b1;
            w_state_nxt = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_D: if (mem_ready_i) w_state_nxt = IDLE;
`ifdef MEM_ARB_ALIGN_CHK_EN
      ERR:     w_state_nxt = IDLE;
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant capture, read-data capture and one-cycle ack generation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_hi  <= '0;
      r_lsb      <= '0;
      r_size     <= SZ_WORD;
      r_we       <= 1'b0;
      r_signed   <= 1'b0;
      r_src      <= SRC_IF;
      r_be       <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      if (w_grant_d) begin
        r_addr_hi <= d_addr_i[ADDR_W-1:2];
        r_lsb     <= d_addr_i[1:0];
        r_size    <= d_size_i;
        r_we      <= d_we_i;
        r_signed  <= d_signed_i;
        r_src     <= SRC_D;
        r_be      <= w_be;
        r_wdata   <= w_wdata;
`ifdef MEM_ARB_ALIGN_CHK_EN
        // A misaligned request never reaches the bus; ack it straight away
        if (w_misalign) begin
          r_d_ack   <= 1'b1;
          r_d_rdata <= '0;
        end
`endif
      end else if (w_grant_if) begin
        r_addr_hi <= if_addr_i[ADDR_W-1:2];
        r_lsb     <= 2'b00;
        r_size    <= SZ_WORD;
        r_we      <= 1'b0;
        r_signed  <= 1'b0;
        r_src     <= SRC_IF;
        r_be      <= 4'b1111;
      end
      if (w_busy && mem_ready_i) begin
        if (r_src == SRC_IF) begin
          r_if_rdata <= mem_rdata_i;
          r_if_ack   <= 1'b1;
        end else begin
          r_d_rdata <= r_we ? 32'd0 : w_ld_data;
          r_d_ack   <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_ARB_ALIGN_CHK_EN
  logic r_d_err;

  // Error flag travels with the ack of a rejected misaligned request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_d_err <= 1'b0;
    else        r_d_err <= w_grant_d & w_misalign;
  end

  assign d_err_o = r_d_err;
`else
  logic w_unused_misalign;
  assign w_unused_misalign = w_misalign;
  assign d_err_o           = 1'b0;
`endif

  assign mem_req_o   = w_busy;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = {r_addr_hi, 2'b00};
  assign mem_be_o    = r_be;
  assign mem_wdata_o = r_wdata;
  assign if_rdata_o  = r_if_rdata;
  assign if_ack_o    = r_if_ack;
  assign d_rdata_o   = r_d_rdata;
  assign d_ack_o     = r_d_ack;

endmodule
